tio_wb_cmd_master: RTL and testbench
====================================

Name: tio_wb_cmd_master

Overview:
Wishbone initiator that turns a command stream (from the TURF control path or a housekeeping sequencer) into single classic-cycle Wishbone reads and writes on the TURFIO register bus. It drives the targets on that bus: the ID/control block, clock monitors and shift-register modules. Every command produces exactly one response carrying the read data and a termination status. A timeout and bounded retry guarantee a response even when a target never answers, for example when a crossing target waits on a dead clock.

Parameters:
ADDR_WIDTH, 22, Wishbone byte-address width; bits [1:0] of commands are ignored and driven 0.
TIMEOUT_CYCLES, 1024, cycles cyc/stb may stay asserted without termination before abort; range 2..65535.
MAX_RETRY, 3, number of re-issues after wb_rty_i before reporting RTY; 0 disables retry.

Ports:
wb_clk_i  in  1  single clock for the block and the bus.
wb_rst_n_i  in  1  reset, asynchronous, active-low.
cmd_valid_i  in  1  command valid.
cmd_ready_o  out  1  command accepted when valid and ready are both high.
cmd_we_i  in  1  1 = write, 0 = read.
cmd_adr_i  in  ADDR_WIDTH  byte address.
cmd_dat_i  in  32  write data.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response consumed.
rsp_dat_o  out  32  read data; 0 for writes and for failed reads.
rsp_status_o  out  2  0 ACK, 1 ERR, 2 RTY, 3 TIMEOUT.
busy_o  out  1  high whenever the FSM is not in IDLE.
wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe (identical in this block).
wb_we_o  out  1  write enable.
wb_adr_o  out  ADDR_WIDTH  address.
wb_dat_o  out  32  write data.
wb_sel_o  out  4  always 4'hF.
wb_dat_i  in  32  read data.
wb_ack_i, wb_err_i, wb_rty_i  in  1 each  cycle terminations.

Behaviour:
- Reset: all outputs 0, except wb_sel_o = 4'hF. FSM goes to IDLE and both counters clear.
- Reset asserted mid-transaction drops cyc/stb immediately (asynchronous). The in-flight response is discarded and never emitted.
- All wb_* outputs are registered. wb_adr_o, wb_we_o and wb_dat_o hold stable from stb rise until the cycle after termination. This matters because targets commit writes on their ack cycle.
- FSM states: IDLE, BUS, GAP, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake at edge N: latch we/adr/dat, clear the retry and timeout counters, and enter BUS. cyc/stb are high from edge N onward.
- BUS:
  - Termination is sampled at each edge.
  - Priority when several terminations are high together: err > ack > rty.
  - ack: capture wb_dat_i (reads only; writes leave rsp_dat = 0), status ACK, clear cyc/stb at that same edge, go to RESP.
  - err: status ERR, rsp_dat = 0, clear cyc/stb, go to RESP.
  - rty with retry_cnt < MAX_RETRY: clear cyc/stb, increment retry_cnt, go to GAP.
  - rty with retry_cnt == MAX_RETRY: status RTY, go to RESP.
  - No termination: timeout counter increments. When it reaches TIMEOUT_CYCLES-1 with no termination that edge: clear cyc/stb, status TIMEOUT, go to RESP.
  - A termination arriving on the same edge as the timeout wins over TIMEOUT.
- GAP: one idle bus cycle, then reassert cyc/stb with the same latched command, clear the timeout counter, return to BUS.
- RESP:
  - rsp_valid_o = 1 and rsp_dat/status held stable until rsp_ready_i.
  - On the handshake edge, return to IDLE; cmd_ready_o goes high the following cycle.
  - No new command is accepted while a response is pending (one outstanding transaction).
- Terminations seen while cyc is low are ignored.
- Latency against a registered-ack target: command handshake at edge N, ack sampled at N+2, rsp_valid_o high after N+2. Minimum accept-to-response is 2 cycles.
- Counter widths: timeout $clog2(TIMEOUT_CYCLES+1); retry $clog2(MAX_RETRY+1), minimum 1 bit. Neither counter wraps: both saturate by construction.

Decomposition:
- Package tio_wb_pkg holds the rsp_status typedef (ST_ACK=0, ST_ERR=1, ST_RTY=2, ST_TIMEOUT=3) and the FSM state enum. Other Wishbone initiators reuse it.
- No sub-module. The timeout counter stays inline.

Test Plan:
- Read 0x000 from a registered-ack target returning "TFIO" -> one stb pulse, ack at N+2, rsp_dat = 32'h5446494F, status 0, wb_adr_o/wb_we_o stable through the ack cycle.
- Write 0x010 with data 0x1A5 -> wb_dat_o = 0x1A5 and we = 1 held through ack, rsp_dat = 0, status 0; a follow-up read of 0x010 returns 0x1A5.
- Silent target, TIMEOUT_CYCLES = 16 -> cyc high exactly 16 cycles, then dropped, status 3, rsp_dat = 0.
- Target answers rty three times, then ack, with MAX_RETRY = 3 -> four stb rises, each separated by one low cycle, final status 0; with rty four times -> status 2.
- err and ack asserted together -> status 1. Back-to-back commands with rsp_ready_i held low 5 cycles -> cmd_ready_o stays low and the response stays stable until it is consumed.
- wb_rst_n_i pulsed low while in BUS -> cyc/stb drop without waiting for a clock edge, no response emitted, next command completes normally.

Source files
------------

// File: rtl/tio_wb_pkg.sv
// Shared types for the TURFIO Wishbone initiators: response status codes,
// initiator FSM states and the fixed byte-select value.
package tio_wb_pkg;

   typedef enum logic [1:0] {
      ST_ACK     = 2'd0,
      ST_ERR     = 2'd1,
      ST_RTY     = 2'd2,
      ST_TIMEOUT = 2'd3
   } rsp_status_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_GAP  = 2'd2,
      S_RESP = 2'd3
   } wb_state_e;

   localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/tio_wb_cmd_master.sv
// Command-stream to Wishbone classic-cycle initiator. One command in flight,
// exactly one response per command, with bounded retry and a bus timeout so a
// dead target can never stall the command path.
module tio_wb_cmd_master
   import tio_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 22,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   // command stream
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [31:0]           cmd_dat_i,
   // response stream
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_dat_o,
   output logic [1:0]            rsp_status_o,
   output logic                  busy_o,
   // Wishbone initiator
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [31:0]           wb_dat_o,
   output logic [3:0]            wb_sel_o,
   input  logic [31:0]           wb_dat_i,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   // Word-aligned address: the two byte-offset bits are forced to zero.
   localparam logic [ADDR_WIDTH-1:0] ADR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   wb_state_e   state;
   rsp_status_e rsp_status;
   logic [TW-1:0] tmo_cnt;
   logic [RW-1:0] retry_cnt;
   logic          cyc_q;

   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign wb_sel_o     = WB_SEL_ALL;
   assign rsp_status_o = rsp_status;
   assign busy_o       = (state != S_IDLE);

   // Command FSM: accepts a command, runs the bus cycle with retry/timeout,
   // then holds the response until consumed. All outputs are registered.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state       <= S_IDLE;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_status  <= ST_ACK;
         cyc_q       <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         tmo_cnt     <= '0;
         retry_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_ready_o && cmd_valid_i) begin
                  cmd_ready_o <= 1'b0;
                  wb_we_o     <= cmd_we_i;
                  wb_adr_o    <= cmd_adr_i & ADR_MASK;
                  wb_dat_o    <= cmd_dat_i;
                  tmo_cnt     <= '0;
                  retry_cnt   <= '0;
                  cyc_q       <= 1'b1;
                  state       <= S_BUS;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end

            S_BUS: begin
               if (wb_err_i) begin
                  cyc_q       <= 1'b0;
                  rsp_status  <= ST_ERR;
                  rsp_dat_o   <= '0;
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end else if (wb_ack_i) begin
                  cyc_q       <= 1'b0;
                  rsp_status  <= ST_ACK;
                  rsp_dat_o   <= wb_we_o ? '0 : wb_dat_i;
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end else if (wb_rty_i) begin
                  cyc_q <= 1'b0;
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= S_GAP;
                  end else begin
                     rsp_status  <= ST_RTY;
                     rsp_dat_o   <= '0;
                     rsp_valid_o <= 1'b1;
                     state       <= S_RESP;
                  end
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  cyc_q       <= 1'b0;
                  rsp_status  <= ST_TIMEOUT;
                  rsp_dat_o   <= '0;
                  rsp_valid_o <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_GAP: begin
               // Re-issue the latched command after one idle bus cycle.
               tmo_cnt <= '0;
               cyc_q   <= 1'b1;
               state   <= S_BUS;
            end

            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end
            end

            default: begin
               cyc_q <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tio_wb_cmd_master.sv
// Directed bench for tio_wb_cmd_master with a registered-ack target model
// that can also stay silent, retry a given number of times, or err+ack.
module tb_tio_wb_cmd_master;

   localparam int unsigned AW = 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [31:0]   cmd_dat = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_dat;
   logic [1:0]    rsp_status;
   logic          busy;
   logic          wb_cyc, wb_stb, wb_we;
   logic [AW-1:0] wb_adr;
   logic [31:0]   wb_dat_o;
   logic [3:0]    wb_sel;
   logic [31:0]   t_dat = '0;
   logic          t_ack = 1'b0, t_err = 1'b0, t_rty = 1'b0;

   tio_wb_cmd_master #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(16),
      .MAX_RETRY     (3)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_status_o(rsp_status),
      .busy_o      (busy),
      .wb_cyc_o    (wb_cyc),
      .wb_stb_o    (wb_stb),
      .wb_we_o     (wb_we),
      .wb_adr_o    (wb_adr),
      .wb_dat_o    (wb_dat_o),
      .wb_sel_o    (wb_sel),
      .wb_dat_i    (t_dat),
      .wb_ack_i    (t_ack),
      .wb_err_i    (t_err),
      .wb_rty_i    (t_rty)
   );

   always #5 clk = ~clk;

   // ---------------- target model ----------------
   // mode 0: registered ack with 16-word memory, 1: silent,
   // 2: rty rty_n times then ack, 3: err and ack together
   int unsigned tgt_mode = 0;
   int unsigned rty_n    = 0;
   bit          mem_init = 1'b1;
   int unsigned rty_done = 0;
   logic [31:0] mem [16];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h5446494F;
      end
      if (!wb_cyc && !busy) rty_done <= 0;
      if (wb_cyc && wb_stb && !(t_ack || t_err || t_rty)) begin
         case (tgt_mode)
            0: begin
               t_ack <= 1'b1;
               if (wb_we) mem[wb_adr[5:2]] <= wb_dat_o;
               t_dat <= wb_we ? 32'h0 : mem[wb_adr[5:2]];
            end
            2: begin
               if (rty_done < rty_n) begin
                  t_rty    <= 1'b1;
                  rty_done <= rty_done + 1;
               end else begin
                  t_ack <= 1'b1;
                  t_dat <= mem[wb_adr[5:2]];
               end
            end
            3: begin
               t_err <= 1'b1;
               t_ack <= 1'b1;
               t_dat <= 32'hDEADBEEF;
            end
            default: ;
         endcase
      end else begin
         t_ack <= 1'b0;
         t_err <= 1'b0;
         t_rty <= 1'b0;
      end
   end

   // ---------------- bus monitor (monotonic counters) ----------------
   int unsigned   n_rise = 0, n_cyc_hi = 0, n_stab_err = 0;
   int unsigned   last_gap = 0, low_run = 0;
   bit            low_valid = 1'b0, prev_stb = 1'b0, prev_cyc = 1'b0;
   logic [AW-1:0] ref_adr = '0;
   logic          ref_we = 1'b0;
   logic [31:0]   ref_dat = '0;

   always @(negedge clk) begin
      if (wb_cyc) n_cyc_hi++;
      if (wb_stb && !prev_stb) begin
         n_rise++;
         ref_adr = wb_adr;
         ref_we  = wb_we;
         ref_dat = wb_dat_o;
         if (low_valid) last_gap = low_run;
         low_valid = 1'b0;
      end else if ((wb_cyc || prev_cyc) &&
                   (wb_adr != ref_adr || wb_we != ref_we || wb_dat_o != ref_dat)) begin
         n_stab_err++;
      end
      if (!busy) begin
         low_valid = 1'b0;
      end else if (!wb_stb) begin
         if (prev_stb) begin
            low_valid = 1'b1;
            low_run   = 1;
         end else if (low_valid) begin
            low_run++;
         end
      end
      prev_stb = wb_stb;
      prev_cyc = wb_cyc;
   end

   // ---------------- checking ----------------
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
      bit hs = 1'b0;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin
            hs = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("cmd_handshake", {31'b0, hs}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = i - 1;
            break;
         end
      end
      if (lat < 0) check("rsp_wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume(output logic [31:0] d, output logic [1:0] st);
      d  = rsp_dat;
      st = rsp_status;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                         output logic [31:0] d, output logic [1:0] st, output int lat);
      @(negedge clk);
      send_cmd(we, adr, dat);
      wait_rsp(lat);
      consume(d, st);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic [1:0]  st;
      int          lat;
      int unsigned r0, c0, s0;
      bit          saw_rsp;

      // reset state
      #2;
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
      check("rst_stb", {31'b0, wb_stb}, 32'd0);
      check("rst_sel", {28'b0, wb_sel}, 32'hF);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_adr", {10'b0, wb_adr}, 32'd0);
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      rst_n = 1'b1;

      // registered-ack read of the ID word
      tgt_mode = 0;
      r0 = n_rise; s0 = n_stab_err;
      do_txn(1'b0, 22'h000, 32'h0, d, st, lat);
      check("rd_id_latency", 32'(lat), 32'd2);
      check("rd_id_data", d, 32'h5446494F);
      check("rd_id_status", {30'b0, st}, 32'd0);
      check("rd_id_stb_pulses", n_rise - r0, 32'd1);
      check("rd_id_stable", n_stab_err - s0, 32'd0);
      check("rd_id_we", {31'b0, ref_we}, 32'd0);

      // write with unaligned address bits, then read back
      s0 = n_stab_err;
      do_txn(1'b1, 22'h013, 32'h1A5, d, st, lat);
      check("wr_status", {30'b0, st}, 32'd0);
      check("wr_rsp_dat", d, 32'd0);
      check("wr_adr_aligned", {10'b0, ref_adr}, 32'h010);
      check("wr_we", {31'b0, ref_we}, 32'd1);
      check("wr_dat", ref_dat, 32'h1A5);
      check("wr_stable", n_stab_err - s0, 32'd0);
      do_txn(1'b0, 22'h010, 32'h0, d, st, lat);
      check("rdback_data", d, 32'h1A5);
      check("rdback_status", {30'b0, st}, 32'd0);

      // silent target -> timeout after 16 cycles of cyc
      tgt_mode = 1;
      c0 = n_cyc_hi;
      do_txn(1'b0, 22'h004, 32'h0, d, st, lat);
      check("tmo_cyc_cycles", n_cyc_hi - c0, 32'd16);
      check("tmo_status", {30'b0, st}, 32'd3);
      check("tmo_data", d, 32'd0);

      // three retries then ack
      tgt_mode = 2; rty_n = 3;
      r0 = n_rise;
      do_txn(1'b0, 22'h000, 32'h0, d, st, lat);
      check("rty3_stb_rises", n_rise - r0, 32'd4);
      check("rty3_gap", last_gap, 32'd1);
      check("rty3_status", {30'b0, st}, 32'd0);
      check("rty3_data", d, 32'h5446494F);

      // four retries exhaust MAX_RETRY
      rty_n = 4;
      r0 = n_rise;
      do_txn(1'b0, 22'h000, 32'h0, d, st, lat);
      check("rty4_stb_rises", n_rise - r0, 32'd4);
      check("rty4_status", {30'b0, st}, 32'd2);
      check("rty4_data", d, 32'd0);

      // err and ack together: err wins
      tgt_mode = 3;
      do_txn(1'b0, 22'h000, 32'h0, d, st, lat);
      check("errack_status", {30'b0, st}, 32'd1);
      check("errack_data", d, 32'd0);

      // response backpressure with a second command waiting
      tgt_mode = 0;
      @(negedge clk);
      send_cmd(1'b0, 22'h000, 32'h0);
      wait_rsp(lat);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 22'h014; cmd_dat = 32'h77;
      for (int i = 0; i < 5; i++) begin
         check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         check("bp_rsp_dat", rsp_dat, 32'h5446494F);
         check("bp_rsp_status", {30'b0, rsp_status}, 32'd0);
         @(negedge clk);
      end
      consume(d, st);
      check("bp_ready_after", {31'b0, cmd_ready}, 32'd1);
      check("bp_valid_after", {31'b0, rsp_valid}, 32'd0);
      send_cmd(1'b1, 22'h014, 32'h77);
      wait_rsp(lat);
      consume(d, st);
      check("bp_wr2_status", {30'b0, st}, 32'd0);
      do_txn(1'b0, 22'h014, 32'h0, d, st, lat);
      check("bp_rd2_data", d, 32'h77);

      // asynchronous reset while in BUS
      tgt_mode = 1;
      @(negedge clk);
      send_cmd(1'b0, 22'h020, 32'h0);
      repeat (3) @(negedge clk);
      check("arst_pre_cyc", {31'b0, wb_cyc}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cyc", {31'b0, wb_cyc}, 32'd0);
      check("arst_stb", {31'b0, wb_stb}, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_rsp = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) saw_rsp = 1'b1;
      end
      check("arst_no_rsp", {31'b0, saw_rsp}, 32'd0);
      tgt_mode = 0;
      do_txn(1'b0, 22'h010, 32'h0, d, st, lat);
      check("arst_next_data", d, 32'h1A5);
      check("arst_next_status", {30'b0, st}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
